id_ex_decode_stage: RTL
=======================

// Module: id_ex_decode_stage
// PURPOSE
//  Producer end of the ALU operand/AluType interface: decodes an RV32I instruction from fetch and
//  registers ALU operands, AluType and control into the ID/EX pipeline register feeding the ALU.
//  One-deep pipeline stage with valid/ready backpressure, stall hold and flush-to-bubble.
// PARAMETERS
//  XLEN      32   datapath width; only 32 is supported
//  RESET_PC  0    value of ex_pc after reset
// PORTS
//  clk           in   1    system clock; all state on rising edge
//  rst           in   1    reset: synchronous, active-high
//  if_valid      in   1    fetch presents an instruction this cycle
//  if_instr      in   32   instruction word
//  if_pc         in   32   PC of if_instr
//  id_ready      out  1    stage accepts if_instr this cycle
//  ex_stall      in   1    EX cannot accept; hold the ID/EX register
//  flush         in   1    squash: next ID/EX content is a bubble
//  rs1_addr      out  5    regfile read address 1 = if_instr[19:15] (combinational)
//  rs2_addr      out  5    regfile read address 2 = if_instr[24:20] (combinational)
//  rf_rdata1     in   32   regfile data for rs1_addr, same cycle
//  rf_rdata2     in   32   regfile data for rs2_addr, same cycle
//  ex_valid      out  1    ID/EX holds a live instruction
//  ex_pc         out  32   PC of the held instruction
//  ex_operand1   out  32   ALU Operand1
//  ex_operand2   out  32   ALU Operand2
//  ex_alu_type   out  4    ALU AluType code
//  ex_imm        out  32   decoded immediate (branch/jump target, store offset)
//  ex_rs2_data   out  32   store data / branch compare operand
//  ex_rd         out  5    destination register
//  ex_funct3     out  3    funct3 for load/store width and branch condition
//  ex_reg_write  out  1    write rd in WB
//  ex_mem_read   out  1    load
//  ex_mem_write  out  1    store
//  ex_branch     out  1    conditional branch
//  ex_jump       out  1    JAL/JALR
//  ex_illegal    out  1    unrecognised opcode/funct
// BEHAVIOUR
//  - Reset: all ex_* outputs 0 except ex_pc=RESET_PC; id_ready=1 the cycle rst deasserts.
//  - id_ready = !ex_stall (combinational). Transfer when if_valid & id_ready.
//  - Latency 1: instruction accepted at edge N appears on ex_* after edge N.
//  - Update rule per edge, in priority order: rst > flush > ex_stall > load.
//    flush: ex_valid<=0, all control bits <=0, datapath fields don't-care; flush wins over stall.
//    ex_stall (no flush): every ex_* register holds its value.
//    load: ex_valid<=if_valid; if !if_valid, control bits forced 0 (bubble).
//  - Control bits (reg_write, mem_read, mem_write, branch, jump) are never 1 while ex_valid=0.
//  - Decode (opcode -> operand1 / operand2 / AluType):
//    OP     : rs1 / rs2 / by funct3; funct7[5] selects SUB vs ADD (000), SRA vs SRL (101)
//    OP-IMM : rs1 / imm_i / by funct3; SLLI/SRLI/SRAI use shamt=instr[24:20], instr[30] -> SRA
//    LOAD   : rs1 / imm_i / ADD, mem_read=1;  STORE: rs1 / imm_s / ADD, mem_write=1, reg_write=0
//    BRANCH : rs1 / rs2 / SUB, branch=1, reg_write=0; ex_imm=imm_b
//    LUI    : x / imm_u / LUI;   AUIPC: pc / imm_u / ADD
//    JAL/JALR: pc / 32'd4 / ADD, jump=1 (link value); ex_imm=imm_j / imm_i
//  - rd=x0 forces ex_reg_write=0.
//  - Illegal: unknown opcode, or OP with funct7 not in {0x00,0x20}, or funct7=0x20 on funct3
//    other than 000/101 -> ex_illegal=1, reg_write/mem_*/branch/jump=0, ex_alu_type=ADD.
//  - Immediates sign-extended to 32 bits; imm_b/imm_j bit 0 = 0; imm_u low 12 bits = 0.
// STRUCTURE
//  - Shared Parameters.v: AluType codes (ADD..LUI, reused by the ALU), opcode constants
//    (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR).
//  - Sub-module imm_gen: combinational, instr[31:0] -> imm_i/s/b/u/j selected by opcode.
//  - This module: combinational decode + one ID/EX register bank with the update rule above.
// TESTING
//  1. rst=1 two cycles -> all ex_* = 0, ex_pc=RESET_PC; after release id_ready=1.
//  2. instr 0x40208133 (sub x2,x1,x2), rdata1=5, rdata2=3 -> next cycle ex_valid=1, SUB, op1=5, op2=3, rd=2, reg_write=1.
//  3. instr 0x40335293 (srai x5,x6,3), rdata1=0x80000000 -> SRA, op1=0x80000000, op2=3, rd=5.
//  4. instr 0x123450B7 (lui x1,0x12345) -> LUI, op2=0x12345000; then pc=0x100 jal -> op1=0x100, op2=4, jump=1.
//  5. ex_stall=1 for 3 cycles with new valid instr -> ex_* held, id_ready=0; release -> new instr on ex_* next cycle.
//  6. flush=1 with ex_stall=1 -> ex_valid=0, controls 0 next cycle; instr 0x0000007F -> ex_illegal=1, reg_write=0.

Source files
------------

// File: rtl/id_ex_decode_stage_pkg.sv
// Shared definitions for the ID/EX decode stage: AluType codes (also used by the ALU) and
// RV32I major opcodes.
package id_ex_decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // alt selects SUB over ADD and SRA over SRL; ignored for the other funct3 values
    function automatic alu_type_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_type_e res;
        res = ALU_ADD;
        case (funct3)
            3'b000: res = alt ? ALU_SUB : ALU_ADD;
            3'b001: res = ALU_SLL;
            3'b010: res = ALU_SLT;
            3'b011: res = ALU_SLTU;
            3'b100: res = ALU_XOR;
            3'b101: res = alt ? ALU_SRA : ALU_SRL;
            3'b110: res = ALU_OR;
            3'b111: res = ALU_AND;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_ex_decode_stage_imm_gen.sv
// Immediate generator: builds the sign-extended RV32I immediate selected by the opcode.
module id_ex_decode_stage_imm_gen
    import id_ex_decode_stage_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};

    always_comb begin
        o_imm = 32'd0;
        case (i_instr[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR: o_imm = w_imm_i;
            OPC_STORE:                     o_imm = w_imm_s;
            OPC_BRANCH:                    o_imm = w_imm_b;
            OPC_LUI, OPC_AUIPC:            o_imm = w_imm_u;
            OPC_JAL:                       o_imm = w_imm_j;
            default:                       o_imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_ex_decode_stage.sv
// RV32I decode stage: decodes the fetched instruction and registers ALU operands, AluType and
// control into the ID/EX register, with valid/ready backpressure, stall hold and flush.
module id_ex_decode_stage
    import id_ex_decode_stage_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_valid,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_id_ready,
    input  logic            i_ex_stall,
    input  logic            i_flush,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    input  logic [XLEN-1:0] i_rf_rdata1,
    input  logic [XLEN-1:0] i_rf_rdata2,
    output logic            o_ex_valid,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_operand1,
    output logic [XLEN-1:0] o_ex_operand2,
    output logic [3:0]      o_ex_alu_type,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [4:0]      o_ex_rd,
    output logic [2:0]      o_ex_funct3,
    output logic            o_ex_reg_write,
    output logic            o_ex_mem_read,
    output logic            o_ex_mem_write,
    output logic            o_ex_branch,
    output logic            o_ex_jump,
    output logic            o_ex_illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [31:0]     w_imm;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    alu_type_e       w_alu;
    logic            w_rw;
    logic            w_mr;
    logic            w_mw;
    logic            w_br;
    logic            w_jp;
    logic            w_ill;

    assign w_opcode   = i_if_instr[6:0];
    assign w_funct3   = i_if_instr[14:12];
    assign w_funct7   = i_if_instr[31:25];
    assign w_rd       = i_if_instr[11:7];
    assign o_rs1_addr = i_if_instr[19:15];
    assign o_rs2_addr = i_if_instr[24:20];
    assign o_id_ready = !i_ex_stall;

    id_ex_decode_stage_imm_gen u_imm_gen (
        .i_instr (i_if_instr),
        .o_imm   (w_imm)
    );

    always_comb begin
        w_op1 = i_rf_rdata1;
        w_op2 = i_rf_rdata2;
        w_alu = ALU_ADD;
        w_rw  = 1'b0;
        w_mr  = 1'b0;
        w_mw  = 1'b0;
        w_br  = 1'b0;
        w_jp  = 1'b0;
        w_ill = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == 7'h00 ||
                    (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
                    w_alu = alu_from_funct3(w_funct3, w_funct7[5]);
                    w_rw  = 1'b1;
                end else begin
                    w_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                w_rw = 1'b1;
                // shifts take shamt from the rs2 field; instr[30] only matters for SRAI
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_op2 = {{(XLEN-5){1'b0}}, i_if_instr[24:20]};
                    w_alu = alu_from_funct3(w_funct3, i_if_instr[30]);
                end else begin
                    w_op2 = w_imm;
                    w_alu = alu_from_funct3(w_funct3, 1'b0);
                end
            end
            OPC_LOAD: begin
                w_op2 = w_imm;
                w_rw  = 1'b1;
                w_mr  = 1'b1;
            end
            OPC_STORE: begin
                w_op2 = w_imm;
                w_mw  = 1'b1;
            end
            OPC_BRANCH: begin
                w_alu = ALU_SUB;
                w_br  = 1'b1;
            end
            OPC_LUI: begin
                w_op1 = '0;
                w_op2 = w_imm;
                w_alu = ALU_LUI;
                w_rw  = 1'b1;
            end
            OPC_AUIPC: begin
                w_op1 = i_if_pc;
                w_op2 = w_imm;
                w_rw  = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                w_op1 = i_if_pc;
                w_op2 = XLEN'(4);
                w_jp  = 1'b1;
                w_rw  = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ex_valid     <= 1'b0;
            o_ex_pc        <= RESET_PC;
            o_ex_operand1  <= '0;
            o_ex_operand2  <= '0;
            o_ex_alu_type  <= 4'd0;
            o_ex_imm       <= '0;
            o_ex_rs2_data  <= '0;
            o_ex_rd        <= 5'd0;
            o_ex_funct3    <= 3'd0;
            o_ex_reg_write <= 1'b0;
            o_ex_mem_read  <= 1'b0;
            o_ex_mem_write <= 1'b0;
            o_ex_branch    <= 1'b0;
            o_ex_jump      <= 1'b0;
            o_ex_illegal   <= 1'b0;
        end else if (i_flush) begin
            o_ex_valid     <= 1'b0;
            o_ex_reg_write <= 1'b0;
            o_ex_mem_read  <= 1'b0;
            o_ex_mem_write <= 1'b0;
            o_ex_branch    <= 1'b0;
            o_ex_jump      <= 1'b0;
            o_ex_illegal   <= 1'b0;
        end else if (!i_ex_stall) begin
            o_ex_valid     <= i_if_valid;
            o_ex_pc        <= i_if_pc;
            o_ex_operand1  <= w_op1;
            o_ex_operand2  <= w_op2;
            o_ex_alu_type  <= w_alu;
            o_ex_imm       <= w_imm;
            o_ex_rs2_data  <= i_rf_rdata2;
            o_ex_rd        <= w_rd;
            o_ex_funct3    <= w_funct3;
            o_ex_reg_write <= i_if_valid && w_rw && (w_rd != 5'd0);
            o_ex_mem_read  <= i_if_valid && w_mr;
            o_ex_mem_write <= i_if_valid && w_mw;
            o_ex_branch    <= i_if_valid && w_br;
            o_ex_jump      <= i_if_valid && w_jp;
            o_ex_illegal   <= i_if_valid && w_ill;
        end
    end

endmodule
